alu_pipe: RTL and testbench

Registered, handshaked successor to the team's combinational ALU, parametrised in data width. It accepts one operation per valid/ready transfer and returns a registered result with zero/carry/overflow/illegal flags. Rotates work for any `BITS`. An iterative shift-add multiply runs over multiple cycles. The block sits between the instruction decode stage and register-file write-back, and its output register absorbs back-pressure.

---
 rtl/alu_pipe.sv | 158 +++++++++++++++
 tb/tb_alu_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Registered, valid/ready handshaked ALU with an iterative shift-add multiplier.
// Non-multiply ops complete on the accept edge; multiply takes BITS further edges.
module alu_pipe #(
    parameter int unsigned BITS  = 8,
    parameter int unsigned ALUOP = 4,
    localparam int unsigned SHW  = $clog2(BITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ALUOP-1:0] aluFunction,
    input  logic [BITS-1:0]  vectorA,
    input  logic [BITS-1:0]  vectorB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BITS-1:0]  aluResult,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [BITS:0] BitsW = (BITS + 1)'(BITS);

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e              state_q;
    logic [SHW-1:0]      cnt_q;
    logic [2*BITS-1:0]   acc_q;
    logic [2*BITS-1:0]   mcand_q;
    logic [BITS-1:0]     mplier_q;
    logic [BITS-1:0]     res_q;
    logic                carry_q;
    logic                ovf_q;
    logic                ill_q;
    logic                out_valid_q;

    logic                accept;
    logic                is_mul;
    logic [BITS-1:0]     alu_res;
    logic                alu_carry;
    logic                alu_ovf;
    logic                alu_ill;
    logic [BITS:0]       add_full;
    logic [BITS-1:0]     diff;
    logic                b_big;
    logic [SHW-1:0]      sh_amt;
    logic [BITS:0]       rot_mod;
    logic [SHW-1:0]      rot_amt;
    logic [2*BITS-1:0]   rot_r2;
    logic [2*BITS-1:0]   rot_l2;
    logic [2*BITS-1:0]   acc_sum;

    assign in_ready  = (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign aluResult = res_q;
    assign zero      = (res_q == '0);
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;

    always_comb begin
        add_full = {1'b0, vectorA} + {1'b0, vectorB};
        diff     = vectorA - vectorB;
        b_big    = ({1'b0, vectorB} >= BitsW);
        sh_amt   = vectorB[SHW-1:0];
        rot_mod  = {1'b0, vectorB} % BitsW;
        rot_amt  = rot_mod[SHW-1:0];
        // Rotate by shifting a doubled copy so an amount of 0 needs no special case.
        rot_r2   = {vectorA, vectorA} >> rot_amt;
        rot_l2   = {vectorA, vectorA} << rot_amt;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_ill   = 1'b0;
        is_mul    = 1'b0;
        case (aluFunction)
            ALUOP'(1): begin
                alu_res   = add_full[BITS-1:0];
                alu_carry = add_full[BITS];
                alu_ovf   = (vectorA[BITS-1] == vectorB[BITS-1]) &&
                            (add_full[BITS-1] != vectorA[BITS-1]);
            end
            ALUOP'(2): begin
                alu_res   = diff;
                alu_carry = (vectorA < vectorB);
                alu_ovf   = (vectorA[BITS-1] != vectorB[BITS-1]) &&
                            (diff[BITS-1] != vectorA[BITS-1]);
            end
            ALUOP'(3):  alu_res = vectorA ^ vectorB;
            ALUOP'(4):  alu_res = vectorA & vectorB;
            ALUOP'(5):  alu_res = vectorA | vectorB;
            ALUOP'(6):  alu_res = b_big ? '0 : (vectorA << sh_amt);
            ALUOP'(7):  alu_res = b_big ? '0 : (vectorA >> sh_amt);
            ALUOP'(8):  alu_res = rot_r2[BITS-1:0];
            ALUOP'(9):  alu_res = rot_l2[2*BITS-1:BITS];
            ALUOP'(10): is_mul  = 1'b1;
            default:    alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept && is_mul) begin
                        mcand_q  <= {{BITS{1'b0}}, vectorA};
                        mplier_q <= vectorB;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= StMul;
                    end else if (accept) begin
                        res_q       <= alu_res;
                        carry_q     <= alu_carry;
                        ovf_q       <= alu_ovf;
                        ill_q       <= alu_ill;
                        out_valid_q <= 1'b1;
                    end
                end
                StMul: begin
                    acc_q    <= acc_sum;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    // Output is free here: entering MUL required in_ready.
                    if (cnt_q == SHW'(BITS - 1)) begin
                        res_q       <= acc_sum[BITS-1:0];
                        carry_q     <= |acc_sum[2*BITS-1:BITS];
                        ovf_q       <= 1'b0;
                        ill_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (BITS=8): directed ops push expectations on accept,
// a monitor pops and compares on every output transfer.
module tb_alu_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] aluFunction;
    logic [7:0] vectorA;
    logic [7:0] vectorB;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] aluResult;
    logic       zero;
    logic       carry;
    logic       overflow;
    logic       illegal;

    int checks = 0;
    int fails  = 0;

    // {result, zero, carry, overflow, illegal}
    logic [11:0] exp_q[$];

    alu_pipe #(.BITS(8), .ALUOP(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .aluFunction (aluFunction),
        .vectorA     (vectorA),
        .vectorB     (vectorB),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .aluResult   (aluResult),
        .zero        (zero),
        .carry       (carry),
        .overflow    (overflow),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] res, input logic c, input logic o, input logic il);
        int n;
        aluFunction = op;
        vectorA     = a;
        vectorB     = b;
        in_valid    = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            exp_q.push_back({res, (res == 8'h00), c, o, il});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Accept edge plus BITS MUL edges: out_valid rises on the 9th edge counting the accept edge.
    task automatic mul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] res,
                       input logic c);
        send(4'd10, a, b, res, c, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("mul_busy_in_ready_out_valid", {30'd0, in_ready, out_valid}, 32'd0);
        end
        @(negedge clk);
        chk("mul_done_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                chk("scoreboard", {20'd0, aluResult, zero, carry, overflow, illegal},
                    {20'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        aluFunction = '0;
        vectorA     = '0;
        vectorB     = '0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_result",    32'(aluResult), 32'd0);
        chk("rst_zero",      32'(zero),      32'd1);
        chk("rst_carry",     32'(carry),     32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_illegal",   32'(illegal),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(4'd1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("add_latency", 32'(out_valid), 32'd1);
        send(4'd1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        chk("add_latency2", 32'(out_valid), 32'd1);
        send(4'd2, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
        send(4'd2, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        send(4'd3, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0, 1'b0);
        send(4'd4, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
        send(4'd5, 8'h50, 8'h05, 8'h55, 1'b0, 1'b0, 1'b0);
        send(4'd6, 8'h81, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0);
        send(4'd6, 8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
        send(4'd7, 8'h81, 8'h03, 8'h10, 1'b0, 1'b0, 1'b0);
        send(4'd7, 8'h81, 8'hC8, 8'h00, 1'b0, 1'b0, 1'b0);
        send(4'd8, 8'h81, 8'h01, 8'hC0, 1'b0, 1'b0, 1'b0);
        send(4'd9, 8'h81, 8'h09, 8'h03, 1'b0, 1'b0, 1'b0);
        send(4'd8, 8'h5A, 8'h08, 8'h5A, 1'b0, 1'b0, 1'b0);

        mul(8'd13, 8'd11, 8'h8F, 1'b0);
        mul(8'h10, 8'h10, 8'h00, 1'b1);
        mul(8'hFF, 8'hFF, 8'h01, 1'b1);

        // Back-pressure: held result must stay put and a pending op must not be taken.
        out_ready = 1'b0;
        send(4'd1, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0);
        aluFunction = 4'd3;
        vectorA     = 8'hFF;
        vectorB     = 8'h0F;
        in_valid    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready",  32'(in_ready),  32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_result",    32'(aluResult), 32'h46);
            chk("bp_zero",      32'(zero),      32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(4'd3, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0);
        chk("no_bubble_valid",  32'(out_valid), 32'd1);
        chk("no_bubble_result", 32'(aluResult), 32'hF0);

        send(4'd15, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1);
        send(4'd0,  8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1);
        send(4'd11, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);

        // Leave a non-reset result in the output registers, then reset mid-multiply.
        send(4'd1, 8'hFF, 8'h02, 8'h01, 1'b1, 1'b0, 1'b0);
        send(4'd10, 8'd3, 8'd5, 8'd15, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_result",    32'(aluResult), 32'd0);
        chk("midrst_zero",      32'(zero),      32'd1);
        chk("midrst_carry",     32'(carry),     32'd0);
        chk("midrst_overflow",  32'(overflow),  32'd0);
        chk("midrst_illegal",   32'(illegal),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_result_after_reset", 32'(seen), 32'd0);

        @(posedge clk);
        #1;
        send(4'd1, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
